// File: rtl/instruction_loader.sv
// Instruction loader: receives a byte stream, packs it big-endian into 32-bit
// words and writes them to consecutive instruction-memory addresses.
//
// state | meaning
// IDLE  | waiting for Start (Error may be set from the last session)
// LOAD  | accepting bytes of the current word, idle-gap timer running
// WRITE | one-cycle write strobe for the assembled word
// DONE  | all requested words written, waiting for the next Start
module instruction_loader #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [ADDR_W:0]   WordCount,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [31:0]       WriteData,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  // The idle cycle that would bring the timer to TIMEOUT aborts the session.
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr, addr_d;
  logic [1:0]          idx, idx_d;
  logic [23:0]         buf_q, buf_d;
  logic [ADDR_W:0]     count, count_d;
  logic [TMR_W-1:0]    timer, timer_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic [31:0]         wr_data_d;
  logic                error_d;
  logic                ready_d, we_d, busy_d, done_d;
  logic                accept;

  assign accept = (state == LOAD) && ByteValid && ByteReady;

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_d   = state;
    addr_d    = addr;
    idx_d     = idx;
    buf_d     = buf_q;
    count_d   = count;
    timer_d   = timer;
    wr_addr_d = WriteAddress;
    wr_data_d = WriteData;
    error_d   = Error;

    case (state)
      IDLE, DONE: begin
        if (Start) begin
          if ((WordCount == '0) || (WordCount > DEPTH_CNT)) begin
            error_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LOAD;
            addr_d  = '0;
            idx_d   = 2'd0;
            timer_d = '0;
            error_d = 1'b0;
            count_d = WordCount;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          timer_d = '0;
          idx_d   = idx + 2'd1;
          case (idx)
            2'd0: buf_d[23:16] = ByteIn;
            2'd1: buf_d[15:8]  = ByteIn;
            2'd2: buf_d[7:0]   = ByteIn;
            default: begin
              state_d   = WRITE;
              wr_addr_d = addr;
              wr_data_d = {buf_q, ByteIn};
            end
          endcase
        end else if (timer == TMR_LAST) begin
          // Partial word is dropped simply by restarting idx on the next Start.
          state_d = IDLE;
          error_d = 1'b1;
          idx_d   = 2'd0;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      WRITE: begin
        // count <= DEPTH, so the address can never step past DEPTH-1.
        if (({1'b0, addr} + (ADDR_W + 1)'(1)) == count) begin
          state_d = DONE;
        end else begin
          addr_d  = addr + ADDR_W'(1);
          idx_d   = 2'd0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == LOAD);
    we_d    = (state_d == WRITE);
    busy_d  = (state_d == LOAD) || (state_d == WRITE);
    done_d  = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      addr         <= '0;
      idx          <= 2'd0;
      buf_q        <= '0;
      count        <= '0;
      timer        <= '0;
      ByteReady    <= 1'b0;
      WriteEnable  <= 1'b0;
      WriteAddress <= '0;
      WriteData    <= 32'h0000_0000;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Error        <= 1'b0;
    end else begin
      state        <= state_d;
      addr         <= addr_d;
      idx          <= idx_d;
      buf_q        <= buf_d;
      count        <= count_d;
      timer        <= timer_d;
      ByteReady    <= ready_d;
      WriteEnable  <= we_d;
      WriteAddress <= wr_addr_d;
      WriteData    <= wr_data_d;
      Busy         <= busy_d;
      Done         <= done_d;
      Error        <= error_d;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a write monitor and hand-built
// expected words.
module tb_instruction_loader;

  localparam int ADDR_W = 6;

  logic              Clk;
  logic              Reset_n;
  logic              Start;
  logic [ADDR_W:0]   WordCount;
  logic [7:0]        ByteIn;
  logic              ByteValid;
  logic              ByteReady;
  logic              WriteEnable;
  logic [ADDR_W-1:0] WriteAddress;
  logic [31:0]       WriteData;
  logic              Busy;
  logic              Done;
  logic              Error;

  int errors = 0;
  int checks = 0;

  int unsigned wr_addr_q[$];
  logic [31:0] wr_data_q[$];

  instruction_loader #(.DEPTH(64), .ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .WordCount(WordCount),
    .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady),
    .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Record every write strobe, sampled mid-cycle.
  always @(negedge Clk) begin
    if (WriteEnable) begin
      wr_addr_q.push_back(int'(WriteAddress));
      wr_data_q.push_back(WriteData);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  function automatic logic [31:0] word_of(input int base, input int k);
    return {pat(base + 4*k), pat(base + 4*k + 1), pat(base + 4*k + 2), pat(base + 4*k + 3)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_load(input int n);
    Start     = 1'b1;
    WordCount = (ADDR_W + 1)'(n);
    tick();
    Start     = 1'b0;
  endtask

  // Offer a byte until it is accepted; ByteValid is left high for streaming.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok        = 1'b0;
    ByteIn    = b;
    ByteValid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = ByteReady;
      tick();
    end
    check_val("byte_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic idle_gap(input int n);
    ByteValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wait_done();
    ByteValid = 1'b0;
    for (int n = 0; n < 10 && !Done; n++) tick();
    check_val("done_reached", {31'b0, Done}, 32'd1);
  endtask

  initial begin
    Reset_n   = 1'b0;
    Start     = 1'b0;
    WordCount = '0;
    ByteIn    = 8'h00;
    ByteValid = 1'b0;
    #12;
    check_val("rst_ready", {31'b0, ByteReady}, 32'd0);
    check_val("rst_busy",  {31'b0, Busy},      32'd0);
    check_val("rst_done",  {31'b0, Done},      32'd0);
    check_val("rst_error", {31'b0, Error},     32'd0);
    check_val("rst_we",    {31'b0, WriteEnable}, 32'd0);
    check_val("rst_data",  WriteData, 32'h0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    tick();

    // Single word, big-endian packing.
    wr_addr_q.delete(); wr_data_q.delete();
    start_load(1);
    check_val("one_busy", {31'b0, Busy}, 32'd1);
    send_byte(8'h80); send_byte(8'h08); send_byte(8'h80); send_byte(8'h14);
    wait_done();
    check_val("one_count", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check_val("one_addr", wr_addr_q[0], 32'd0);
      check_val("one_data", wr_data_q[0], 32'h80088014);
    end
    check_val("one_busy_end",  {31'b0, Busy},      32'd0);
    check_val("one_ready_end", {31'b0, ByteReady}, 32'd0);

    // Full depth, back-to-back stream.
    wr_addr_q.delete(); wr_data_q.delete();
    start_load(64);
    for (int i = 0; i < 256; i++) send_byte(pat(i));
    wait_done();
    check_val("full_count", wr_addr_q.size(), 32'd64);
    if (wr_addr_q.size() == 64) begin
      for (int k = 0; k < 64; k++) begin
        check_val("full_addr", wr_addr_q[k], k);
        check_val("full_data", wr_data_q[k], word_of(0, k));
      end
    end
    check_val("full_busy",  {31'b0, Busy},      32'd0);
    check_val("full_ready", {31'b0, ByteReady}, 32'd0);
    tick();
    check_val("full_done_hold", {31'b0, Done}, 32'd1);

    // Random ByteValid gaps plus an ignored Start in the middle of LOAD.
    wr_addr_q.delete(); wr_data_q.delete();
    start_load(3);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) begin
        ByteValid = 1'b0;
        start_load(1);
      end
      if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 3));
      send_byte(pat(100 + i));
    end
    wait_done();
    check_val("gap_count", wr_addr_q.size(), 32'd3);
    if (wr_addr_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check_val("gap_addr", wr_addr_q[k], k);
        check_val("gap_data", wr_data_q[k], word_of(100, k));
      end
    end

    // Illegal word counts.
    wr_addr_q.delete(); wr_data_q.delete();
    start_load(0);
    check_val("wc0_error", {31'b0, Error}, 32'd1);
    check_val("wc0_done",  {31'b0, Done},  32'd0);
    check_val("wc0_busy",  {31'b0, Busy},  32'd0);
    start_load(65);
    check_val("wc65_error", {31'b0, Error}, 32'd1);
    check_val("wc65_busy",  {31'b0, Busy},  32'd0);
    repeat (3) tick();
    check_val("bad_no_write", wr_addr_q.size(), 32'd0);
    start_load(2);
    check_val("valid_clears_error", {31'b0, Error}, 32'd0);
    check_val("valid_busy",         {31'b0, Busy},  32'd1);
    for (int i = 0; i < 8; i++) send_byte(pat(300 + i));
    wait_done();
    check_val("wc2_count", wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() == 2) check_val("wc2_data1", wr_data_q[1], word_of(300, 1));

    // Idle timeout after two bytes.
    wr_addr_q.delete(); wr_data_q.delete();
    start_load(2);
    send_byte(8'hAA); send_byte(8'hBB);
    ByteValid = 1'b0;
    repeat (254) tick();
    check_val("to_before_error", {31'b0, Error}, 32'd0);
    check_val("to_before_busy",  {31'b0, Busy},  32'd1);
    tick();
    check_val("to_error", {31'b0, Error},     32'd1);
    check_val("to_busy",  {31'b0, Busy},      32'd0);
    check_val("to_ready", {31'b0, ByteReady}, 32'd0);
    check_val("to_no_write", wr_addr_q.size(), 32'd0);
    start_load(1);
    check_val("to_error_cleared", {31'b0, Error}, 32'd0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_done();
    check_val("to_next_count", wr_addr_q.size(), 32'd1);
    if (wr_addr_q.size() == 1) check_val("to_next_data", wr_data_q[0], 32'h11223344);

    // Asynchronous reset in the middle of word 5.
    wr_addr_q.delete(); wr_data_q.delete();
    start_load(8);
    for (int i = 0; i < 23; i++) send_byte(pat(200 + i));
    ByteValid = 1'b0;
    check_val("pre_rst_busy", {31'b0, Busy}, 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check_val("arst_ready", {31'b0, ByteReady},   32'd0);
    check_val("arst_busy",  {31'b0, Busy},        32'd0);
    check_val("arst_we",    {31'b0, WriteEnable}, 32'd0);
    check_val("arst_addr",  {26'b0, WriteAddress}, 32'd0);
    check_val("arst_data",  WriteData, 32'h0);
    check_val("arst_done",  {31'b0, Done},  32'd0);
    check_val("arst_error", {31'b0, Error}, 32'd0);
    tick();
    Reset_n   = 1'b1;
    ByteIn    = pat(223);
    ByteValid = 1'b1;
    repeat (10) tick();
    ByteValid = 1'b0;
    check_val("arst_writes", wr_addr_q.size(), 32'd5);
    check_val("arst_idle_ready", {31'b0, ByteReady}, 32'd0);
    check_val("arst_idle_busy",  {31'b0, Busy},      32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words in the target memory.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning the write address width, with DEPTH = 2^ADDR_W.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of idle cycles allowed between accepted bytes in LOAD.
REQ-004 SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port Start, input, 1 bit: single-cycle request to begin a load session.
REQ-007 SHALL have port WordCount, input, ADDR_W+1 bits: number of words to load, sampled when Start is accepted.
REQ-008 SHALL have port ByteIn, input, 8 bits: program byte stream.
REQ-009 SHALL have port ByteValid, input, 1 bit: ByteIn holds a valid byte.
REQ-010 SHALL have port ByteReady, output, 1 bit: loader can accept a byte this cycle.
REQ-011 SHALL have port WriteEnable, output, 1 bit: instruction memory write strobe.
REQ-012 SHALL have port WriteAddress, output, ADDR_W bits: instruction memory word address.
REQ-013 SHALL have port WriteData, output, 32 bits: instruction word to write.
REQ-014 SHALL have port Busy, output, 1 bit: high in LOAD and WRITE.
REQ-015 SHALL have port Done, output, 1 bit: session completed.
REQ-016 SHALL have port Error, output, 1 bit: sticky error flag.

Function
REQ-017 SHALL implement states IDLE, LOAD, WRITE and DONE; all outputs are registered.
REQ-018 SHALL, in IDLE or DONE with Start=1 and 1<=WordCount<=DEPTH, enter LOAD with address=0, byte index=0, timeout counter=0, Done=0 and Error=0.
REQ-019 SHALL, in IDLE or DONE with Start=1 and WordCount=0 or WordCount>DEPTH, set Error=1, go to IDLE and issue no write.
REQ-020 SHALL ignore Start while in LOAD or WRITE.
REQ-021 SHALL drive ByteReady=1 only in LOAD; a byte is accepted on a rising edge where ByteValid=1 and ByteReady=1.
REQ-022 SHALL assemble bytes big-endian: 1st byte to [31:24], 2nd to [23:16], 3rd to [15:8], 4th to [7:0].
REQ-023 SHALL, on acceptance of the 4th byte, enter WRITE, so that WriteEnable=1 for exactly the next cycle with WriteAddress=current address and WriteData=assembled word.
REQ-024 SHALL hold ByteReady=0 during WRITE; an offered byte is not consumed and remains pending.
REQ-025 SHALL, on leaving WRITE, go to DONE if words written equals WordCount, else increment the address and return to LOAD with byte index=0.
REQ-026 SHALL never increment the address past DEPTH-1 and never issue more than WordCount writes per session.
REQ-027 SHALL hold Done=1 in DONE until the next accepted Start or reset; Busy=0 in DONE.
REQ-028 SHALL, in LOAD, increment the timeout counter each cycle without an accepted byte and clear it on each accepted byte.
REQ-029 SHALL, when the timeout counter reaches TIMEOUT, set Error=1, go to IDLE, discard the partial word and issue no write.
REQ-030 SHALL keep WriteEnable=0 in every state other than WRITE; WriteAddress and WriteData hold their last values outside WRITE.

Reset
REQ-031 SHALL, while Reset_n=0, immediately force state=IDLE and set ByteReady, WriteEnable, Busy, Done and Error to 0, WriteAddress to 0 and WriteData to 0x00000000, independent of Clk.
REQ-032 SHALL discard any partial word or session in progress when reset is asserted mid-operation, and resume in IDLE after Reset_n=1.

Verification
REQ-033 SHALL cover: Start with WordCount=1, bytes 0x80,0x08,0x80,0x14 -> one WriteEnable pulse, address 0, data 0x80088014; then Done=1, Busy=0.
REQ-034 SHALL cover: Start with WordCount=64 and 256 bytes -> writes to addresses 0..63 in order, exactly 64 pulses, Done=1, ByteReady=0 afterwards.
REQ-035 SHALL cover: ByteValid toggled randomly and a byte held during WRITE -> data identical to back-to-back streaming, no byte lost or duplicated.
REQ-036 SHALL cover: Start with WordCount=0, then WordCount=65 -> Error=1, no WriteEnable; a following valid Start clears Error.
REQ-037 SHALL cover: 2 bytes accepted, then 255 idle cycles -> Error=1, state IDLE, no write.
REQ-038 SHALL cover: Reset_n pulled low asynchronously after 3 bytes of word 5 -> all outputs 0 before the next edge, and no write follows.
